// File: rtl/and2_pkg.sv
// Shared constants and helpers for the and2_gate logic-gate block.
// The optional input debouncer is enabled with `define AND2_DEBOUNCE_EN.
package and2_pkg;

    localparam int SYNC_STAGES_DEFAULT     = 2;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;
    localparam int DEBOUNCE_CYCLES_MIN = 2;

    // Counter only ever needs to hold 0 .. cycles-1.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/and2_sw_cond.sv
// One switch conditioner: SYNC_STAGES-deep synchronizer, followed by a
// stability filter when AND2_DEBOUNCE_EN is defined.
module sw_cond
    import and2_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic cond
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
        DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_params
        $error("sw_cond: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef AND2_DEBOUNCE_EN
    localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count;
    logic          filtered;

    // Filtered value only moves after the synced value has disagreed with it
    // for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count    <= '0;
            filtered <= 1'b0;
        end else if (synced == filtered) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            filtered <= synced;
            count    <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign cond = filtered;
`else
    assign cond = synced;
`endif

endmodule

// File: rtl/and2_gate.sv
// Registered two-input AND behind the IceZUM switch pins: SW1 & SW2 -> LED0.
// Define AND2_DEBOUNCE_EN to add a debouncer to each switch path.
module and2_gate
    import and2_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic SW1,
    input  logic SW2,
    output logic LED0
);

    logic s1;
    logic s2;

    sw_cond #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond_sw1 (
        .clk (clk),
        .rstn(rstn),
        .raw (SW1),
        .cond(s1)
    );

    sw_cond #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond_sw2 (
        .clk (clk),
        .rstn(rstn),
        .raw (SW2),
        .cond(s2)
    );

    // Both paths have equal latency, so a simultaneous switch change lands here
    // on one edge and the register hides any skew.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            LED0 <= 1'b0;
        end else begin
            LED0 <= s1 & s2;
        end
    end

endmodule

// File: tb/tb_and2_gate.sv
// Directed, table-driven bench for and2_gate; latency expectations follow
// AND2_DEBOUNCE_EN (3 clocks plain, 19 with the debouncer at defaults).
`timescale 1ns/100ps
module tb_and2_gate;

`ifdef AND2_DEBOUNCE_EN
    localparam int LAT = 2 + 16 + 1;
`else
    localparam int LAT = 2 + 1;
`endif

    typedef struct {
        logic sw1;
        logic sw2;
        logic exp;
    } vec_t;

    logic clk;
    logic rstn;
    logic SW1;
    logic SW2;
    logic LED0;

    int vectorsApplied = 0;
    int miscompares    = 0;

    and2_gate dut (
        .clk (clk),
        .rstn(rstn),
        .SW1 (SW1),
        .SW2 (SW2),
        .LED0(LED0)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic a, input logic b);
        SW1 = a;
        SW2 = b;
    endtask

    task automatic checkOutput(input string name, input logic expected);
        vectorsApplied++;
        if (LED0 !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: LED0=%b, expected %b at %0t", name, LED0, expected, $time);
        end
    endtask

    initial begin
        vec_t table_v[9];
        logic prevExp;

        table_v[0] = '{1'b0, 1'b0, 1'b0};
        table_v[1] = '{1'b0, 1'b1, 1'b0};
        table_v[2] = '{1'b1, 1'b0, 1'b0};
        table_v[3] = '{1'b1, 1'b1, 1'b1};
        table_v[4] = '{1'b1, 1'b0, 1'b0};
        table_v[5] = '{1'b1, 1'b1, 1'b1};
        table_v[6] = '{1'b0, 1'b1, 1'b0};
        table_v[7] = '{1'b1, 1'b1, 1'b1};
        table_v[8] = '{1'b0, 1'b0, 1'b0};

        // Reset held with both switches high: LED0 must stay low.
        rstn = 1'b1;
        applyStimulus(1'b1, 1'b1);
        #1 rstn = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("reset_hold", 1'b0);
        end
        rstn = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkOutput((k == LAT) ? "release_latency_hi" : "release_latency_lo", (k == LAT));
        end
        prevExp = 1'b1;

        // Truth table: old value until the latency elapses, then the new one.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(table_v[i].sw1, table_v[i].sw2);
            repeat (LAT - 1) @(negedge clk);
            checkOutput("table_before_latency", prevExp);
            @(negedge clk);
            checkOutput("table_at_latency", table_v[i].exp);
            repeat (2) @(negedge clk);
            checkOutput("table_settled", table_v[i].exp);
            prevExp = table_v[i].exp;
        end

        // Latency: rise on edge LAT, not LAT-1.
        applyStimulus(1'b0, 1'b0);
        repeat (LAT + 2) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        repeat (LAT - 1) @(negedge clk);
        checkOutput("latency_early", 1'b0);
        @(negedge clk);
        checkOutput("latency_on_time", 1'b1);

        // Short reset pulse between edges: immediate drop, normal recovery.
        rstn = 1'b0;
        #0.5;
        checkOutput("async_reset_drop", 1'b0);
        #0.5 rstn = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkOutput((k == LAT) ? "mid_reset_recover_hi" : "mid_reset_recover_lo", (k == LAT));
        end

`ifdef AND2_DEBOUNCE_EN
        // Bounce on SW1 (10 high, 3 low) is rejected, then a steady high is accepted.
        applyStimulus(1'b0, 1'b1);
        repeat (LAT + 5) @(negedge clk);
        checkOutput("debounce_idle", 1'b0);
        SW1 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("debounce_bounce_hi", 1'b0);
        end
        SW1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("debounce_bounce_lo", 1'b0);
        end
        SW1 = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkOutput((k == LAT) ? "debounce_accept" : "debounce_pending", (k == LAT));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/and2_gate.md
Name: and2_gate

Overview:
- Registered two-input AND for the IceZUM board: two asynchronous switch inputs drive one LED.
- Each switch passes through a synchronizer and, optionally, a debouncer. LED0 is the registered AND of the two conditioned switches.
- Sits directly behind board pins; serves as the reference gate block for the logic-gates family.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain (legal range 2..4).
- DEBOUNCE_CYCLES, 16, consecutive stable clocks required before a debounced input changes (used only with DEBOUNCE_EN; legal range >= 2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset; assertion clears state immediately, release is synchronous to clk.
- SW1  input  1  switch 1, asynchronous to clk.
- SW2  input  1  switch 2, asynchronous to clk.
- LED0  output  1  registered SW1 AND SW2.

Behaviour:
- Reset: all synchronizer flops, debounce counters, filtered values and LED0 are 0 while rstn = 0. LED0 = 0 on the first clock after release.
- Synchronizer: each switch passes through SYNC_STAGES flops; no logic between stages.
- Output register: LED0 <= s1 & s2 every clock, where s1 and s2 are the conditioned switch values.
- Latency without DEBOUNCE_EN: a switch change is visible on LED0 after SYNC_STAGES+1 rising edges. Default is 3 clocks.
- Truth table after latency:
  - 00 -> 0
  - 01 -> 0
  - 10 -> 0
  - 11 -> 1
- Simultaneous change of both switches: each path has identical latency. LED0 reflects the new pair on the same cycle, with no glitch at register level.
- A pulse shorter than one clock may be lost. This is acceptable; no pulse stretching.
- Reset asserted mid-operation: LED0 drops to 0 asynchronously, regardless of switch state. After release, LED0 follows the switches with the normal latency from release.
- No combinational path from SW1/SW2 to LED0.

Optional Feature:
- Macro: AND2_DEBOUNCE_EN.
- Defined: each synchronized input feeds a debouncer.
  - The debouncer holds a filtered value, initially 0, and a counter sized for DEBOUNCE_CYCLES.
  - When the synced value equals the filtered value, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the filtered value takes the synced value and the counter clears.
  - Any return to the filtered value before then clears the counter.
  - Latency becomes SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks. Default is 19.
- Undefined: no debouncer is instantiated; the synced value is used directly. DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package and2_pkg:
  - default SYNC_STAGES and DEBOUNCE_CYCLES constants;
  - a function returning the counter width, clog2(DEBOUNCE_CYCLES).
- Sub-module sw_cond: synchronizer plus optional debouncer for one switch. Ports: clk, rstn, raw in, conditioned out.
  - Instantiated twice, once per switch.
  - and2_gate adds only the AND and the output register.

Test Plan:
- Reset: hold rstn = 0 with SW1 = SW2 = 1 for 5 clocks -> LED0 = 0 throughout. Release -> LED0 = 1 exactly 3 clocks later (default, no debounce).
- Truth table: apply 00, 01, 10, 11, each held 20 ns (larger than the latency at the bench clock) -> LED0 = 0, 0, 0, 1 once each input pair has settled.
- Latency: step SW1 = SW2 from 0 to 1 at one clock edge -> LED0 rises on the 3rd following rising edge, not the 2nd.
- Mid-operation reset: with LED0 = 1, pulse rstn low for 1 ns between edges -> LED0 goes to 0 immediately. LED0 returns to 1 three clocks after release.
- Debounce (AND2_DEBOUNCE_EN, DEBOUNCE_CYCLES = 16), bounce rejection: with SW2 = 1, toggle SW1 high 10 clocks, low 3, high 10 -> LED0 stays 0.
- Debounce acceptance: then hold SW1 high -> LED0 = 1 exactly 19 clocks after the last SW1 rising edge.
